regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of writeback data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register address width (2**ADDR_WIDTH registers).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on posedge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports alu_valid/alu_ready  input/output  1  ALU writeback handshake (requester 0).
REQ-006 SHALL have ports alu_address/alu_data  input  ADDR_WIDTH/DATA_WIDTH  ALU writeback target and value.
REQ-007 SHALL have ports mem_valid/mem_ready, mem_address, mem_data with the same widths and meaning, for the load unit (requester 1).
REQ-008 SHALL have ports issue_valid, issue_address  input  1/ADDR_WIDTH  marks destination register pending.
REQ-009 SHALL have ports read_address_1, read_address_2  input  ADDR_WIDTH  source operands of the instruction in decode.
REQ-010 SHALL have port stall  output  1  decode must hold; a source is pending.
REQ-011 SHALL have ports write_enable, write_address, write_data_in  output  1/ADDR_WIDTH/DATA_WIDTH  register file write port, registered.
REQ-012 SHALL have port busy  output  2**ADDR_WIDTH  scoreboard bit vector, registered.

Function
REQ-013 SHALL grant at most one requester per cycle; ready is combinational, asserted only to the granted requester while its valid is high.
REQ-014 SHALL treat a transfer as valid&ready at a posedge; requesters hold valid, address and data stable until ready.
REQ-015 SHALL drive write_enable/write_address/write_data_in from the accepted transfer exactly 1 cycle after the accept edge; write_enable low in cycles with no accept.
REQ-016 SHALL accept transfers to address 0 (ready asserted) but never assert write_enable for address 0.
REQ-017 SHALL set busy[issue_address] on the edge where issue_valid is high; issue to address 0 is ignored.
REQ-018 SHALL clear busy[a] on the edge where a transfer to address a is accepted.
REQ-019 SHALL, on simultaneous issue and accept to the same address, leave busy set (set wins).
REQ-020 SHALL drive stall = busy[read_address_1] | busy[read_address_2], combinational from registered busy.
REQ-021 SHALL accept a transfer to a register whose busy bit is already clear without error; busy stays clear.
REQ-022 SHALL keep arbitration state in a 1-bit last_grant register updated only on an accept.

Reset
REQ-023 SHALL, while reset is high at a posedge: clear busy to all zeros, write_enable to 0, write_address and write_data_in to 0, last_grant to requester 1 (so requester 0 wins first).
REQ-024 SHALL hold alu_ready and mem_ready low while reset is high; transfers in progress are dropped, not replayed.
REQ-025 SHALL ignore issue_valid while reset is high.

Configuration
REQ-026 SHALL use macro REGFILE_WB_ROUND_ROBIN_EN: defined -> when both valid, grant the requester not equal to last_grant; undefined -> fixed priority, ALU always wins, last_grant unused and optimised away.

Structure
REQ-027 SHALL place DATA_WIDTH/ADDR_WIDTH defaults and requester index constants (REQ_ALU=0, REQ_MEM=1) in the shared regfile package.
REQ-028 SHALL implement the scoreboard as sub-module regfile_scoreboard (busy vector, set/clear, stall lookup); arbiter and write-port register stay in the top.

Verification
REQ-029 SHALL cover: reset, then alu_valid=1 addr=5 data=0xDEADBEEF -> alu_ready same cycle; next cycle write_enable=1, write_address=5, write_data_in=0xDEADBEEF.
REQ-030 SHALL cover: both valid every cycle for 4 cycles with round robin -> grants ALU,MEM,ALU,MEM; with macro undefined -> ALU x4, mem_ready low throughout.
REQ-031 SHALL cover: issue addr=7, then read_address_1=7 -> stall=1 from next cycle; mem writeback to 7 accepted -> stall=0 the cycle after accept.
REQ-032 SHALL cover: same-edge issue addr=9 and alu accept addr=9 -> busy[9]=1 afterwards; write_enable=1 addr=9 next cycle.
REQ-033 SHALL cover: alu writeback to addr 0 -> alu_ready=1, write_enable stays 0; issue to addr 0 -> busy[0] stays 0.
REQ-034 SHALL cover: busy[3]=1 and alu_valid held, reset asserted mid-transfer -> alu_ready=0, busy all zero, write_enable=0 after the reset edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the register-file writeback slice.
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH : default parameter values for the slice.
//   req_e                           : writeback requester index (REQ_ALU=0, REQ_MEM=1).
package regfile_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 5;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending (busy) tracker with decode stall lookup.
// Ports:
//   clock, reset        : single clock, synchronous active-high reset
//   set_valid/address   : mark a destination register pending (address 0 ignored)
//   clear_valid/address : writeback accepted for a register, clears its pending bit
//   read_address_1/2    : decode source operands
//   busy                : registered pending vector, one bit per register
//   stall               : a decode source is pending
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         set_valid,
    input  logic [ADDR_WIDTH-1:0]        set_address,
    input  logic                         clear_valid,
    input  logic [ADDR_WIDTH-1:0]        clear_address,
    input  logic [ADDR_WIDTH-1:0]        read_address_1,
    input  logic [ADDR_WIDTH-1:0]        read_address_2,
    output logic [(2**ADDR_WIDTH)-1:0]   busy,
    output logic                         stall
);

    logic [(2**ADDR_WIDTH)-1:0] busy_q;
    logic [(2**ADDR_WIDTH)-1:0] busy_d;

    // Clear is applied before set so a same-edge issue to the written
    // register leaves it pending.
    always_comb begin
        busy_d = busy_q;
        if (clear_valid) begin
            busy_d[clear_address] = 1'b0;
        end
        if (set_valid && (set_address != '0)) begin
            busy_d[set_address] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy  = busy_q;
    assign stall = busy_q[read_address_1] | busy_q[read_address_2];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates ALU and load-unit writebacks onto a single
// registered register-file write port and tracks pending destinations.
// Ports:
//   clock, reset                        : single clock, synchronous active-high reset
//   alu_valid/ready, alu_address/data   : requester 0 writeback handshake
//   mem_valid/ready, mem_address/data   : requester 1 writeback handshake
//   issue_valid, issue_address          : destination register becomes pending
//   read_address_1/2, stall             : decode operand lookup, stall if pending
//   write_enable/address/data_in        : registered register-file write port
//   busy                                : registered pending vector
// Configuration:
//   REGFILE_WB_ROUND_ROBIN_EN defined   : alternate grants when both requesters are valid
//   undefined (default)                 : fixed priority, ALU always wins
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [ADDR_WIDTH-1:0]        alu_address,
    input  logic [DATA_WIDTH-1:0]        alu_data,
    input  logic                         mem_valid,
    output logic                         mem_ready,
    input  logic [ADDR_WIDTH-1:0]        mem_address,
    input  logic [DATA_WIDTH-1:0]        mem_data,
    input  logic                         issue_valid,
    input  logic [ADDR_WIDTH-1:0]        issue_address,
    input  logic [ADDR_WIDTH-1:0]        read_address_1,
    input  logic [ADDR_WIDTH-1:0]        read_address_2,
    output logic                         stall,
    output logic                         write_enable,
    output logic [ADDR_WIDTH-1:0]        write_address,
    output logic [DATA_WIDTH-1:0]        write_data_in,
    output logic [(2**ADDR_WIDTH)-1:0]   busy
);

    req_e                  grant;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] acc_address;
    logic [DATA_WIDTH-1:0] acc_data;

    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] wa_q, wa_d;
    logic [DATA_WIDTH-1:0] wd_q, wd_d;

`ifdef REGFILE_WB_ROUND_ROBIN_EN
    req_e last_grant_q, last_grant_d;
`endif

    always_comb begin
        grant = REQ_ALU;
        if (alu_valid && mem_valid) begin
`ifdef REGFILE_WB_ROUND_ROBIN_EN
            grant = (last_grant_q == REQ_ALU) ? REQ_MEM : REQ_ALU;
`else
            grant = REQ_ALU;
`endif
        end else if (mem_valid) begin
            grant = REQ_MEM;
        end
    end

    // Ready is suppressed during reset so nothing is accepted (and so
    // nothing is replayed) across the reset edge.
    always_comb begin
        alu_ready   = !reset && alu_valid && (grant == REQ_ALU);
        mem_ready   = !reset && mem_valid && (grant == REQ_MEM);
        accept      = alu_ready || mem_ready;
        acc_address = mem_ready ? mem_address : alu_address;
        acc_data    = mem_ready ? mem_data    : alu_data;
    end

    always_comb begin
        we_d = 1'b0;
        wa_d = wa_q;
        wd_d = wd_q;
        if (accept) begin
            we_d = (acc_address != '0);
            wa_d = acc_address;
            wd_d = acc_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            we_q <= 1'b0;
            wa_q <= '0;
            wd_q <= '0;
        end else begin
            we_q <= we_d;
            wa_q <= wa_d;
            wd_q <= wd_d;
        end
    end

`ifdef REGFILE_WB_ROUND_ROBIN_EN
    always_comb begin
        last_grant_d = last_grant_q;
        if (accept) begin
            last_grant_d = grant;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_q <= REQ_MEM;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign write_enable  = we_q;
    assign write_address = wa_q;
    assign write_data_in = wd_q;

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clock          (clock),
        .reset          (reset),
        .set_valid      (issue_valid),
        .set_address    (issue_address),
        .clear_valid    (accept),
        .clear_address  (acc_address),
        .read_address_1 (read_address_1),
        .read_address_2 (read_address_2),
        .busy           (busy),
        .stall          (stall)
    );

endmodule
